// File: rtl/chess_timer_pkg.sv
// Shared definitions for the chess clock countdown core: FSM state
// encoding, ACTIVE output codes, BCD digit limits and state decoders.
package chess_timer_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RUN_A   = 3'd1;
    localparam logic [2:0] ST_RUN_B   = 3'd2;
    localparam logic [2:0] ST_PAUSE_A = 3'd3;
    localparam logic [2:0] ST_PAUSE_B = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_RUN_A   = ST_RUN_A,
        S_RUN_B   = ST_RUN_B,
        S_PAUSE_A = ST_PAUSE_A,
        S_PAUSE_B = ST_PAUSE_B,
        S_DONE    = ST_DONE
    } state_t;

    localparam logic [1:0] ACT_NONE = 2'b00;
    localparam logic [1:0] ACT_A    = 2'b01;
    localparam logic [1:0] ACT_B    = 2'b10;

    // Largest value of a units digit (s1, m1) and of the tens-of-seconds digit
    localparam logic [3:0] BCD_MAX_9 = 4'd9;
    localparam logic [3:0] BCD_MAX_5 = 4'd5;

    // ACTIVE code for a state: the player whose clock is running or paused
    function automatic logic [1:0] active_code(input state_t s);
        logic [1:0] code;
        case (s)
            S_RUN_A, S_PAUSE_A: code = ACT_A;
            S_RUN_B, S_PAUSE_B: code = ACT_B;
            default:            code = ACT_NONE;
        endcase
        return code;
    endfunction

    // PAUSED indication for a state
    function automatic logic paused_code(input state_t s);
        logic p;
        case (s)
            S_PAUSE_A, S_PAUSE_B: p = 1'b1;
            default:              p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/chess_timer_bcd_mmss_dec.sv
// Combinational one-second decrement of a packed BCD mm:ss value.
// 00:00 is held (never wraps); o_is_zero_next flags a decrement that lands on 00:00.
module bcd_mmss_dec
    import chess_timer_pkg::*;
(
    input  logic [15:0] i_time,
    output logic [15:0] o_time_dec,
    output logic        o_is_zero_next
);

    logic [3:0] w_s1;
    logic [3:0] w_s10;
    logic [3:0] w_m1;
    logic [3:0] w_m10;
    logic       w_b1;
    logic       w_b10;
    logic       w_bm1;

    // Ripple the borrow from seconds-units up to tens-of-minutes
    always_comb begin
        w_s1  = i_time[3:0];
        w_s10 = i_time[7:4];
        w_m1  = i_time[11:8];
        w_m10 = i_time[15:12];
        w_b1  = 1'b0;
        w_b10 = 1'b0;
        w_bm1 = 1'b0;
        o_time_dec     = i_time;
        o_is_zero_next = 1'b0;

        if (i_time == 16'h0000) begin
            o_time_dec     = 16'h0000;
            o_is_zero_next = 1'b0;
        end else begin
            if (w_s1 == 4'd0) begin
                w_s1 = BCD_MAX_9;
                w_b1 = 1'b1;
            end else begin
                w_s1 = w_s1 - 4'd1;
            end

            if (w_b1) begin
                if (w_s10 == 4'd0) begin
                    w_s10 = BCD_MAX_5;
                    w_b10 = 1'b1;
                end else begin
                    w_s10 = w_s10 - 4'd1;
                end
            end else begin
                w_b10 = 1'b0;
            end

            if (w_b10) begin
                if (w_m1 == 4'd0) begin
                    w_m1  = BCD_MAX_9;
                    w_bm1 = 1'b1;
                end else begin
                    w_m1 = w_m1 - 4'd1;
                end
            end else begin
                w_bm1 = 1'b0;
            end

            if (w_bm1) begin
                w_m10 = w_m10 - 4'd1;
            end else begin
                w_m10 = w_m10;
            end

            o_time_dec     = {w_m10, w_m1, w_s10, w_s1};
            o_is_zero_next = ({w_m10, w_m1, w_s10, w_s1} == 16'h0000);
        end
    end

endmodule

// File: rtl/chess_timer.sv
// Two-player chess clock countdown core. Consumes the one-second CE tick,
// decrements the running player's BCD mm:ss time, switches turns on the
// move buttons and raises a sticky flag when a player reaches 00:00.
module chess_timer
    import chess_timer_pkg::*;
#(
    parameter logic [7:0] INIT_MM = 8'h05,
    parameter logic [7:0] INIT_SS = 8'h00
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        CE,
    input  logic        START,
    input  logic        BTN_A,
    input  logic        BTN_B,
    output logic [15:0] TIME_A,
    output logic [15:0] TIME_B,
    output logic [1:0]  ACTIVE,
    output logic        PAUSED,
    output logic        FLAG_A,
    output logic        FLAG_B
);

    localparam logic [15:0] INIT_TIME = {INIT_MM, INIT_SS};

    state_t      r_state;
    logic [15:0] r_time_a;
    logic [15:0] r_time_b;
    logic        r_flag_a;
    logic        r_flag_b;
    logic [1:0]  r_active;
    logic        r_paused;

    state_t      w_state_next;
    logic [15:0] w_time_a_next;
    logic [15:0] w_time_b_next;
    logic        w_flag_a_next;
    logic        w_flag_b_next;

    logic [15:0] w_dec_a;
    logic [15:0] w_dec_b;
    logic        w_zero_a;
    logic        w_zero_b;

    bcd_mmss_dec u_dec_a (
        .i_time         (r_time_a),
        .o_time_dec     (w_dec_a),
        .o_is_zero_next (w_zero_a)
    );

    bcd_mmss_dec u_dec_b (
        .i_time         (r_time_b),
        .o_time_dec     (w_dec_b),
        .o_is_zero_next (w_zero_b)
    );

    // Next-state and datapath decisions; a timeout always beats a button or START
    always_comb begin
        w_state_next  = r_state;
        w_time_a_next = r_time_a;
        w_time_b_next = r_time_b;
        w_flag_a_next = r_flag_a;
        w_flag_b_next = r_flag_b;

        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_state_next = S_RUN_A;
                end else begin
                    w_state_next = S_IDLE;
                end
            end

            S_RUN_A: begin
                if (CE) begin
                    w_time_a_next = w_dec_a;
                end else begin
                    w_time_a_next = r_time_a;
                end

                if (CE && w_zero_a) begin
                    w_flag_a_next = 1'b1;
                    w_state_next  = S_DONE;
                end else if (BTN_A) begin
                    w_state_next = S_RUN_B;
                end else if (START) begin
                    w_state_next = S_PAUSE_A;
                end else begin
                    w_state_next = S_RUN_A;
                end
            end

            S_RUN_B: begin
                if (CE) begin
                    w_time_b_next = w_dec_b;
                end else begin
                    w_time_b_next = r_time_b;
                end

                if (CE && w_zero_b) begin
                    w_flag_b_next = 1'b1;
                    w_state_next  = S_DONE;
                end else if (BTN_B) begin
                    w_state_next = S_RUN_A;
                end else if (START) begin
                    w_state_next = S_PAUSE_B;
                end else begin
                    w_state_next = S_RUN_B;
                end
            end

            S_PAUSE_A: begin
                if (START) begin
                    w_state_next = S_RUN_A;
                end else begin
                    w_state_next = S_PAUSE_A;
                end
            end

            S_PAUSE_B: begin
                if (START) begin
                    w_state_next = S_RUN_B;
                end else begin
                    w_state_next = S_PAUSE_B;
                end
            end

            S_DONE: begin
                if (START) begin
                    w_time_a_next = INIT_TIME;
                    w_time_b_next = INIT_TIME;
                    w_flag_a_next = 1'b0;
                    w_flag_b_next = 1'b0;
                    w_state_next  = S_IDLE;
                end else begin
                    w_state_next = S_DONE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // FSM state, both time registers, flags and the registered status outputs
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_state  <= S_IDLE;
            r_time_a <= INIT_TIME;
            r_time_b <= INIT_TIME;
            r_flag_a <= 1'b0;
            r_flag_b <= 1'b0;
            r_active <= ACT_NONE;
            r_paused <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_time_a <= w_time_a_next;
            r_time_b <= w_time_b_next;
            r_flag_a <= w_flag_a_next;
            r_flag_b <= w_flag_b_next;
            r_active <= active_code(w_state_next);
            r_paused <= paused_code(w_state_next);
        end
    end

    assign TIME_A = r_time_a;
    assign TIME_B = r_time_b;
    assign ACTIVE = r_active;
    assign PAUSED = r_paused;
    assign FLAG_A = r_flag_a;
    assign FLAG_B = r_flag_b;

endmodule

// File: tb/tb_chess_timer.sv
// Directed testbench for chess_timer. Three instances with different
// initial times share the clock and CLR; each has its own stimulus inputs.
module tb_chess_timer;

    logic        CLK;
    logic        CLR;
    logic [2:0]  ce;
    logic [2:0]  start;
    logic [2:0]  btn_a;
    logic [2:0]  btn_b;
    logic [15:0] ta [3];
    logic [15:0] tb [3];
    logic [1:0]  act [3];
    logic        pau [3];
    logic        fa [3];
    logic        fb [3];

    int checks;
    int failures;

    // dut 0: 05:00
    chess_timer #(.INIT_MM(8'h05), .INIT_SS(8'h00)) u_dut0 (
        .CLK(CLK), .CLR(CLR), .CE(ce[0]), .START(start[0]),
        .BTN_A(btn_a[0]), .BTN_B(btn_b[0]),
        .TIME_A(ta[0]), .TIME_B(tb[0]), .ACTIVE(act[0]),
        .PAUSED(pau[0]), .FLAG_A(fa[0]), .FLAG_B(fb[0])
    );

    // dut 1: 10:00
    chess_timer #(.INIT_MM(8'h10), .INIT_SS(8'h00)) u_dut1 (
        .CLK(CLK), .CLR(CLR), .CE(ce[1]), .START(start[1]),
        .BTN_A(btn_a[1]), .BTN_B(btn_b[1]),
        .TIME_A(ta[1]), .TIME_B(tb[1]), .ACTIVE(act[1]),
        .PAUSED(pau[1]), .FLAG_A(fa[1]), .FLAG_B(fb[1])
    );

    // dut 2: 00:02
    chess_timer #(.INIT_MM(8'h00), .INIT_SS(8'h02)) u_dut2 (
        .CLK(CLK), .CLR(CLR), .CE(ce[2]), .START(start[2]),
        .BTN_A(btn_a[2]), .BTN_B(btn_b[2]),
        .TIME_A(ta[2]), .TIME_B(tb[2]), .ACTIVE(act[2]),
        .PAUSED(pau[2]), .FLAG_A(fa[2]), .FLAG_B(fb[2])
    );

    // free-running clock, 10 time-unit period
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // drive one cycle of inputs to instance d, clock it, sample 1 unit later
    task automatic step(input int d, input logic c, input logic s, input logic a, input logic b);
        ce[d]    = c;
        start[d] = s;
        btn_a[d] = a;
        btn_b[d] = b;
        @(posedge CLK);
        #1;
        ce    = 3'b000;
        start = 3'b000;
        btn_a = 3'b000;
        btn_b = 3'b000;
    endtask

    task automatic ticks(input int d, input int n);
        for (int i = 0; i < n; i++) step(d, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        ce    = 3'b000;
        start = 3'b000;
        btn_a = 3'b000;
        btn_b = 3'b000;
        CLR   = 1'b1;
        #12;
        chk("rst_time_a", ta[0], 16'h0500);
        chk("rst_time_b", tb[0], 16'h0500);
        chk("rst_active", 16'(act[0]), 16'h0000);
        chk("rst_paused", 16'(pau[0]), 16'h0000);
        chk("rst_flags", 16'({fa[0], fb[0]}), 16'h0000);
        #4 CLR = 1'b0;
        @(posedge CLK);
        #1;

        // ---- dut0: start and first ticks ----
        ticks(0, 2);
        chk("idle_ce_ignored", ta[0], 16'h0500);
        step(0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("start_active_a", 16'(act[0]), 16'h0001);
        ticks(0, 3);
        chk("run_a_3ce", ta[0], 16'h0457);
        chk("run_a_b_untouched", tb[0], 16'h0500);

        // ---- turn switch ----
        step(0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("btn_b_ignored_act", 16'(act[0]), 16'h0001);
        step(0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("btn_b_ignored_ce", ta[0], 16'h0456);
        step(0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("btn_a_switch", 16'(act[0]), 16'h0002);
        ticks(0, 61);
        chk("run_b_61ce", tb[0], 16'h0359);
        chk("run_b_a_frozen", ta[0], 16'h0456);

        // ---- pause ----
        step(0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("pause_paused", 16'(pau[0]), 16'h0001);
        chk("pause_active", 16'(act[0]), 16'h0002);
        ticks(0, 5);
        step(0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("pause_time_hold", tb[0], 16'h0359);
        chk("pause_btn_ignored", 16'(act[0]), 16'h0002);
        step(0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("resume_unpaused", 16'(pau[0]), 16'h0000);
        ticks(0, 1);
        chk("resume_dec_b", tb[0], 16'h0358);

        // ---- simultaneous events in RUN_B ----
        step(0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("btn_beats_start_act", 16'(act[0]), 16'h0001);
        chk("btn_beats_start_pau", 16'(pau[0]), 16'h0000);
        step(0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("ce_btn_dec_a", ta[0], 16'h0455);
        chk("ce_btn_switch", 16'(act[0]), 16'h0002);
        step(0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("ce_start_dec_b", tb[0], 16'h0357);
        chk("ce_start_paused", 16'(pau[0]), 16'h0001);

        // ---- dut1: borrow chain 10:00 -> 09:59 ----
        chk("d1_init", ta[1], 16'h1000);
        step(1, 1'b0, 1'b1, 1'b0, 1'b0);
        ticks(1, 1);
        chk("d1_borrow_chain", ta[1], 16'h0959);
        chk("d1_b_untouched", tb[1], 16'h1000);

        // ---- dut2: timeout with simultaneous button ----
        step(2, 1'b0, 1'b1, 1'b0, 1'b0);
        ticks(2, 1);
        chk("d2_one_left", ta[2], 16'h0001);
        chk("d2_no_flag_yet", 16'(fa[2]), 16'h0000);
        step(2, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("d2_zero", ta[2], 16'h0000);
        chk("d2_flag_a", 16'(fa[2]), 16'h0001);
        chk("d2_done_active", 16'(act[2]), 16'h0000);
        chk("d2_done_paused", 16'(pau[2]), 16'h0000);
        step(2, 1'b1, 1'b0, 1'b1, 1'b1);
        ticks(2, 2);
        chk("d2_done_hold_a", ta[2], 16'h0000);
        chk("d2_done_hold_b", tb[2], 16'h0002);
        chk("d2_done_hold_act", 16'(act[2]), 16'h0000);
        chk("d2_flag_sticky", 16'(fa[2]), 16'h0001);

        // ---- reload from DONE ----
        step(2, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("reload_a", ta[2], 16'h0002);
        chk("reload_b", tb[2], 16'h0002);
        chk("reload_flags", 16'({fa[2], fb[2]}), 16'h0000);
        chk("reload_idle", 16'(act[2]), 16'h0000);
        ticks(2, 1);
        chk("reload_idle_ce", ta[2], 16'h0002);

        // ---- player B timeout: flag beats START ----
        step(2, 1'b0, 1'b1, 1'b0, 1'b0);
        step(2, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("d2_run_b", 16'(act[2]), 16'h0002);
        ticks(2, 1);
        step(2, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("d2_b_zero", tb[2], 16'h0000);
        chk("d2_flag_b", 16'(fb[2]), 16'h0001);
        chk("d2_flag_b_not_paused", 16'(pau[2]), 16'h0000);
        chk("d2_flag_a_clear", 16'(fa[2]), 16'h0000);

        // ---- dut0: CLR mid-run ----
        step(0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("d0_back_run_b", 16'(act[0]), 16'h0002);
        step(0, 1'b0, 1'b0, 1'b0, 1'b1);
        ticks(0, 10);
        chk("d0_10ce", ta[0], 16'h0445);
        #2 CLR = 1'b1;
        #1;
        chk("clr_async_a", ta[0], 16'h0500);
        chk("clr_async_b", tb[0], 16'h0500);
        chk("clr_async_act", 16'(act[0]), 16'h0000);
        #3 CLR = 1'b0;
        @(posedge CLK);
        #1;
        step(0, 1'b0, 1'b1, 1'b0, 1'b0);
        ticks(0, 1);
        chk("post_clr_one_tick", ta[0], 16'h0459);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/chess_timer.md
# chess_timer

Two-player countdown core of the chess clock. It consumes the one-cycle CE tick from the upstream prescaler (one tick = one second) and decrements the active player's BCD mm:ss time. Player turns are switched by move buttons, and a flag is raised when a player's time reaches 00:00. It sits between the prescaler and the display multiplexer, which reads TIME_A/TIME_B directly.

## Interface
- INIT_MM, 8'h05: initial minutes, packed BCD, 00–99.
- INIT_SS, 8'h00: initial seconds, packed BCD, 00–59. INIT_MM:INIT_SS must be nonzero.
- CLK  in  1  system clock. Reset CLR, asynchronous, active-high; clock CLK.
- CLR  in  1  asynchronous active-high reset.
- CE  in  1  one-second tick, single-cycle pulse from the prescaler.
- START  in  1  single-cycle pulse, already debounced: start, pause/resume, or reload.
- BTN_A  in  1  single-cycle pulse: player A ends move.
- BTN_B  in  1  single-cycle pulse: player B ends move.
- TIME_A  out  16  player A time, BCD {m10,m1,s10,s1}.
- TIME_B  out  16  player B time, same format.
- ACTIVE  out  2  01 = A running, 10 = B running, 00 = none.
- PAUSED  out  1  high in either pause state.
- FLAG_A  out  1  A ran out of time; sticky until reload.
- FLAG_B  out  1  B ran out of time; sticky until reload.

## Operation
- States: IDLE, RUN_A, RUN_B, PAUSE_A, PAUSE_B, DONE.
- IDLE:
  - START -> RUN_A (A moves first).
  - CE, BTN_A and BTN_B are ignored.
- RUN_A:
  - CE decrements TIME_A.
  - BTN_A -> RUN_B.
  - START -> PAUSE_A.
  - BTN_B is ignored.
- RUN_B: symmetric to RUN_A.
- PAUSE_x:
  - START -> RUN_x.
  - CE and the buttons are ignored.
- DONE:
  - All inputs are ignored except START.
  - START reloads both times to INIT, clears both flags, and goes to IDLE.
- Decrement rule (BCD):
  - s1: 0 -> 9 with borrow.
  - s10: 0 -> 5 with borrow.
  - m1: 0 -> 9 with borrow.
  - m10: decrements on borrow.
  - 00:00 is never decremented.
- Zero detect: when the decrement produces 00:00, set FLAG_x and go to DONE on the same edge.
- Simultaneous events in RUN_A (RUN_B is symmetric):
  - CE + BTN_A: decrement A, then switch to RUN_B.
  - If that decrement reaches 00:00, the flag wins: go to DONE and ignore the button.
  - CE + START: decrement applied, then go to PAUSE_A; the flag rule takes priority.
  - BTN_A + START without CE: BTN_A wins, go to RUN_B; START is dropped.
  - BTN_A and BTN_B together: only the active player's button counts.
- ACTIVE is decoded from the state: 01 in RUN_A/PAUSE_A, 10 in RUN_B/PAUSE_B, 00 otherwise.

## Timing
- All outputs are registered or decoded from registered state; there are no combinational input-to-output paths.
- Reset values:
  - TIME_A = TIME_B = {INIT_MM, INIT_SS}.
  - FLAG_A = FLAG_B = 0.
  - State = IDLE, ACTIVE = 00, PAUSED = 0.
- Latency:
  - A CE sampled at edge n changes TIME_x after edge n.
  - A button sampled at edge n changes ACTIVE after edge n.
  - The flag is visible in the same cycle that TIME shows 0000.
- CLR mid-operation immediately restores all reset values, with no tick lost or gained afterwards.
- CE may be high for several consecutive cycles in simulation; each cycle counts as one second.

## Structure
- Shared package holds:
  - state encoding localparams (3-bit);
  - ACTIVE codes;
  - the BCD digit max constants 9 and 5.
- One natural sub-module: bcd_mmss_dec, combinational.
  - Inputs: 16-bit BCD time.
  - Outputs: the decremented value and an is_zero_next indication.
  - Instantiated twice, once per player.
- The top level holds the FSM and the two time registers.

## Test plan
- Reset and start:
  - Assert CLR; expect TIME_A = TIME_B = 16'h0500, ACTIVE = 00.
  - Pulse START, then 3 CE; expect TIME_A = 16'h0457, TIME_B = 16'h0500, ACTIVE = 01.
- Turn switch:
  - In RUN_A, pulse BTN_B; expect no change.
  - Pulse BTN_A; expect ACTIVE = 10.
  - 61 CE; expect TIME_B = 16'h0359.
- Borrow chain: INIT_MM = 8'h10, INIT_SS = 8'h00, START, 1 CE; expect TIME_A = 16'h0959.
- Timeout with a simultaneous button:
  - INIT_MM = 8'h00, INIT_SS = 8'h02, START, 1 CE.
  - Then drive CE and BTN_A in the same cycle.
  - Expect TIME_A = 0000, FLAG_A = 1, state DONE, ACTIVE = 00.
  - Further CE/BTN pulses cause no change.
- Pause:
  - RUN_B, START; expect PAUSED = 1, ACTIVE = 10.
  - 5 CE; expect TIME_B unchanged.
  - START; expect the next CE to decrement B.
- Reload and reset mid-run:
  - In DONE, START; expect both times = INIT, flags = 0, IDLE.
  - In RUN_A after 10 CE, assert CLR asynchronously between edges; expect immediate reset values.
